// File: rtl/mipi_rx_output_gearbox.sv
// CSI-2 receive output gearbox: buffers depacked 64-bit words and re-serialises each as two
// 32-bit beats with line framing, line sync, completed-line count and sticky overflow.
module mipi_rx_output_gearbox #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned LCNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_active_i,
  input  logic              line_valid_i,
  input  logic [63:0]       data_i,
  input  logic              data_valid_i,
  output logic [31:0]       out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              lsync_o,
  output logic [LCNT_W-1:0] line_count_o,
  output logic              overflow_o
);

  localparam int unsigned       Depth   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  PtrOne  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [LCNT_W-1:0] LcntOne = {{(LCNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  logic              fa_q, lv_q;
  logic              frame_start, line_fall, word_acc;
  logic              hold_vld_q, hold_vld_d;
  logic [63:0]       hold_data_q, hold_data_d;
  logic              push, pop, fifo_wr, fifo_drop, fifo_empty, fifo_full;
  logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_prev;
  logic [63:0]       mem_data [Depth];
  logic              mem_last [Depth];
  logic [63:0]       rd_data;
  logic              rd_last;
  state_e            state_q, state_d;
  logic [31:0]       out_data_q, out_data_d, ent_hi_q, ent_hi_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d, ent_last_q, ent_last_d;
  logic              lsync_q, lsync_d, ovf_q, ovf_d, accept;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;

  // Input side: a word only leaves the hold register once we know whether it ends the line.
  always_comb begin
    frame_start = frame_active_i & ~fa_q;
    line_fall   = lv_q & ~line_valid_i;
    word_acc    = data_valid_i & line_valid_i & ~frame_start;
    push        = hold_vld_q & ~frame_start & (word_acc | line_fall);
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (frame_start) begin
      hold_vld_d = 1'b0;
    end else if (word_acc) begin
      hold_vld_d  = 1'b1;
      hold_data_d = data_i;
    end else if (line_fall) begin
      hold_vld_d = 1'b0;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_wr    = push & (~fifo_full | pop);
  assign fifo_drop  = push & fifo_full & ~pop;
  assign wr_prev    = wr_ptr_q - PtrOne;
  assign rd_data    = mem_data[rd_ptr_q[FIFO_AW-1:0]];
  assign rd_last    = mem_last[rd_ptr_q[FIFO_AW-1:0]];
  assign accept     = out_valid_q & out_ready_i;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ent_hi_d    = ent_hi_q;
    ent_last_d  = ent_last_q;
    lsync_d     = lsync_q;
    lcnt_d      = lcnt_q;
    ovf_d       = ovf_q | fifo_drop;
    pop         = 1'b0;

    case (state_q)
      StIdle: pop = ~fifo_empty;
      StLo: begin
        if (accept) begin
          out_data_d = ent_hi_q;
          out_last_d = ent_last_q;
          state_d    = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      out_data_d  = rd_data[31:0];
      ent_hi_d    = rd_data[63:32];
      ent_last_d  = rd_last;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      state_d     = StLo;
    end

    if (accept && out_last_q) begin
      lsync_d = 1'b0;
      lcnt_d  = lcnt_q + LcntOne;
    end else if (accept && !lsync_q) begin
      lsync_d = 1'b1;
    end

    // Frame start wins over every other event in the cycle.
    if (frame_start) begin
      pop         = 1'b0;
      state_d     = StIdle;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      lsync_d     = 1'b0;
      lcnt_d      = '0;
      ovf_d       = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
    if (frame_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // A dropped end-of-line moves its last flag onto the newest stored entry.
  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      mem_data[wr_ptr_q[FIFO_AW-1:0]] <= hold_data_q;
      mem_last[wr_ptr_q[FIFO_AW-1:0]] <= line_fall;
    end else if (fifo_drop && line_fall) begin
      mem_last[wr_prev[FIFO_AW-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fa_q        <= 1'b0;
      lv_q        <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ent_hi_q    <= '0;
      ent_last_q  <= 1'b0;
      lsync_q     <= 1'b0;
      lcnt_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      fa_q        <= frame_active_i;
      lv_q        <= line_valid_i;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ent_hi_q    <= ent_hi_d;
      ent_last_q  <= ent_last_d;
      lsync_q     <= lsync_d;
      lcnt_q      <= lcnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign lsync_o      = lsync_q;
  assign line_count_o = lcnt_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_mipi_rx_output_gearbox.sv
// Bench for mipi_rx_output_gearbox: line-level reference model of the expected beat stream,
// compared against beats captured at the output handshake.
module tb_mipi_rx_output_gearbox;

  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned LCNT_W  = 3;
  localparam int          DEPTH   = 4;
  localparam int          LMOD    = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              frame_active = 1'b0;
  logic              line_valid = 1'b0;
  logic [63:0]       data = '0;
  logic              data_valid = 1'b0;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              lsync;
  logic [LCNT_W-1:0] line_count;
  logic              overflow;

  typedef struct packed {
    logic [31:0]       data;
    logic              last;
    logic              lsync;
    logic [LCNT_W-1:0] lcnt;
  } beat_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [63:0] words[$];
  int          total = 0;
  int          bad = 0;
  int          lines_done = 0;
  int          ready_mode = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  mipi_rx_output_gearbox #(.FIFO_AW(FIFO_AW), .LCNT_W(LCNT_W)) dut (
    .clk_i(clk), .reset_i(reset_n), .frame_active_i(frame_active), .line_valid_i(line_valid),
    .data_i(data), .data_valid_i(data_valid), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_last_o(out_last), .lsync_o(lsync),
    .line_count_o(line_count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // Capture every beat the consumer takes, with the sync/count seen just before it is taken.
  always @(negedge clk) begin
    beat_t b;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid && (out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      if (out_valid && out_ready) begin
        b.data = out_data; b.last = out_last; b.lsync = lsync; b.lcnt = line_count;
        got_q.push_back(b);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode == 1) out_ready = !out_ready ? 1'b1 : ($urandom_range(3) != 0);
    else if (ready_mode == 2) out_ready = ~out_ready;
  endtask

  // Expected stream for one line: low half then high half of each word, last on the final beat.
  task automatic model_line();
    beat_t       b;
    logic [63:0] w;
    int          n = words.size();
    for (int j = 0; j < 2 * n; j++) begin
      w = words[j/2];
      b.data  = (j % 2 == 0) ? w[31:0] : w[63:32];
      b.last  = (j == 2 * n - 1);
      b.lsync = (j != 0);
      b.lcnt  = LCNT_W'(lines_done % LMOD);
      exp_q.push_back(b);
    end
    if (n > 0) lines_done++;
  endtask

  task automatic drive_line(input int n, input int gmin, input int gmax);
    logic [63:0] w;
    words.delete();
    line_valid = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      words.push_back(w);
      data = w; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      if (gmax > 0) repeat ($urandom_range(gmax, gmin)) tick();
    end
    line_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_drain(input int limit);
    int c = 0;
    while ((got_q.size() < exp_q.size() || out_valid) && c < limit) begin
      tick();
      c++;
    end
    repeat (3) tick();
  endtask

  task automatic new_frame();
    frame_active = 1'b0;
    tick();
    frame_active = 1'b1;
    tick();
    tick();
    lines_done = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
    if (lsync !== 1'b0) begin bad++; $display("FAIL reset_lsync: got %b want 0", lsync); end
    if (line_count !== '0) begin bad++; $display("FAIL reset_lcnt: got %0d want 0", line_count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_line();
    new_frame();
    ready_mode = 0; out_ready = 1'b1;
    drive_line(3, 0, 0);
    model_line();
    wait_drain(200);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total += 2;
    if (line_count !== 3'd1) begin bad++; $display("FAIL basic_lcnt: got %0d want 1", line_count); end
    if (lsync !== 1'b0) begin bad++; $display("FAIL basic_lsync_end: got %b want 0", lsync); end
  endtask

  task automatic test_single_and_empty();
    logic [63:0] w;
    got_q.delete(); exp_q.delete(); words.delete();
    w = {$urandom, $urandom};
    line_valid = 1'b1; data = w; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; line_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got %b want 0", out_valid); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== w[31:0]) begin
      bad++; $display("FAIL latency: got v=%b d=%h want v=1 d=%h", out_valid, out_data, w[31:0]);
    end
    words.push_back(w);
    model_line();
    wait_drain(200);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL single_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
    drive_line(0, 0, 0);
    repeat (5) tick();
    total += 2;
    if (got_q.size() !== 0) begin bad++; $display("FAIL empty_beats: got %0d want 0", got_q.size()); end
    if (line_count !== LCNT_W'(lines_done % LMOD)) begin
      bad++; $display("FAIL empty_lcnt: got %0d want %0d", line_count, lines_done % LMOD);
    end
  endtask

  task automatic test_stall_toggle();
    got_q.delete(); exp_q.delete();
    stall_err = 0;
    ready_mode = 2;
    drive_line(4, 0, 0);
    model_line();
    wait_drain(300);
    ready_mode = 0; out_ready = 1'b1;
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total += 2;
    if (stall_err !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", stall_err); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL stall_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete();
    ready_mode = 0; out_ready = 1'b0;
    drive_line(8, 0, 0);
    repeat (2) tick();
    total += 3;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
    if (got_q.size() !== 0) begin bad++; $display("FAIL ovf_early: got %0d want 0", got_q.size()); end
    // Only what fits (FIFO plus output register) survives; framing stays on the survivor.
    while (words.size() > DEPTH + 1) void'(words.pop_back());
    model_line();
    out_ready = 1'b1;
    wait_drain(200);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_frame_flush();
    ready_mode = 0; out_ready = 1'b0;
    line_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      data = {$urandom, $urandom}; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    frame_active = 1'b0;
    tick();
    frame_active = 1'b1; data = {$urandom, $urandom}; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    if (line_count !== '0) begin bad++; $display("FAIL flush_lcnt: got %0d want 0", line_count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf: got %b want 0", overflow); end
    if (lsync !== 1'b0) begin bad++; $display("FAIL flush_lsync: got %b want 0", lsync); end
    got_q.delete(); exp_q.delete(); lines_done = 0;
    out_ready = 1'b1;
    line_valid = 1'b0;
    repeat (5) tick();
    total++;
    if (got_q.size() !== 0) begin bad++; $display("FAIL flush_stray: got %0d want 0", got_q.size()); end
    drive_line(2, 0, 2);
    model_line();
    wait_drain(200);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL flush_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL flush_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_lines();
    got_q.delete(); exp_q.delete();
    ready_mode = 1;
    for (int l = 0; l < 12; l++) begin
      drive_line($urandom_range(6, 0), 5, 8);
      model_line();
    end
    wait_drain(2000);
    ready_mode = 0; out_ready = 1'b1;
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total += 2;
    if (line_count !== LCNT_W'(lines_done % LMOD)) begin
      bad++; $display("FAIL rand_lcnt: got %0d want %0d", line_count, lines_done % LMOD);
    end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rand_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_hi();
    ready_mode = 0; out_ready = 1'b1;
    line_valid = 1'b1; data = {$urandom, $urandom}; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; line_valid = 1'b0;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_last !== 1'b1) begin
      bad++; $display("FAIL hi_stall: got v=%b l=%b want v=1 l=1", out_valid, out_last);
    end
    #2 reset_n = 1'b0;
    #1;
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL areset_data: got %h want 0", out_data); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL areset_last: got %b want 0", out_last); end
    if (lsync !== 1'b0) begin bad++; $display("FAIL areset_lsync: got %b want 0", lsync); end
    if (line_count !== '0) begin bad++; $display("FAIL areset_lcnt: got %0d want 0", line_count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL areset_ovf: got %b want 0", overflow); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    tick();
    got_q.delete(); exp_q.delete(); lines_done = 0;
    out_ready = 1'b1;
    drive_line(2, 0, 0);
    model_line();
    wait_drain(200);
    total++;
    if (got_q.size() !== 4) begin bad++; $display("FAIL post_reset_count: got %0d want 4", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL post_reset_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (line_count !== 3'd1) begin bad++; $display("FAIL post_reset_lcnt: got %0d want 1", line_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_line();
    test_single_and_empty();
    test_stall_toggle();
    test_overflow();
    test_frame_flush();
    test_random_lines();
    test_reset_mid_hi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
